// File: rtl/cordic_polar.sv
// Rectangular-to-polar converter: iterative vectoring-mode CORDIC returning the
// gain-compensated magnitude and atan2(N, M) scaled so that +-pi = +-2^(ANG_W-1).
module cordic_polar #(
  parameter int IN_W  = 15,
  parameter int MAG_W = 16,
  parameter int ANG_W = 13,
  parameter int ITER  = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  M,
  input  logic [IN_W-1:0]  N,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] mag,
  output logic [ANG_W-1:0] ang,
  output logic             busy
);

  localparam int XW = IN_W + 2;
  localparam int ZW = ANG_W + 3;
  localparam int PW = XW + 17;
  localparam int SH = 22 - ANG_W;
  localparam logic [31:0] ATAN_RND = (32'd1 << SH) >> 1;
  localparam logic [PW-1:0] GAIN_INV = PW'(39797);
  localparam logic [PW-1:0] MAG_RND = PW'(32768);
  localparam logic signed [ZW-1:0] Z_HALF = {2'b01, {(ZW-2){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_OUT} state_t;

  // atan(2^-i)/pi scaled by 2^24; rescaled with rounding to the z resolution.
  function automatic logic [23:0] atan_base(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_base = 24'd4194304;
      5'd1:    atan_base = 24'd2476042;
      5'd2:    atan_base = 24'd1308273;
      5'd3:    atan_base = 24'd664100;
      5'd4:    atan_base = 24'd333339;
      5'd5:    atan_base = 24'd166832;
      5'd6:    atan_base = 24'd83436;
      5'd7:    atan_base = 24'd41721;
      5'd8:    atan_base = 24'd20861;
      5'd9:    atan_base = 24'd10430;
      5'd10:   atan_base = 24'd5215;
      5'd11:   atan_base = 24'd2608;
      5'd12:   atan_base = 24'd1304;
      5'd13:   atan_base = 24'd652;
      5'd14:   atan_base = 24'd326;
      5'd15:   atan_base = 24'd163;
      5'd16:   atan_base = 24'd81;
      5'd17:   atan_base = 24'd41;
      5'd18:   atan_base = 24'd20;
      5'd19:   atan_base = 24'd10;
      default: atan_base = '0;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [XW-1:0]    x_sh, y_sh;
  logic signed [ZW-1:0]    z_q, z_d, atan_z;
  logic [4:0]              cnt_q, cnt_d;
  logic                    zero_q, zero_d;
  logic [MAG_W-1:0]        mag_q, mag_d;
  logic [ANG_W-1:0]        ang_q, ang_d;
  logic [PW-1:0]           mag_full;
  logic                    accept;

  always_comb begin
    in_ready  = !reset && ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
    mag       = mag_q;
    ang       = ang_q;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    mag_d    = mag_q;
    ang_d    = ang_q;
    x_sh     = x_q >>> cnt_q;
    y_sh     = y_q >>> cnt_q;
    atan_z   = ZW'((32'(atan_base(cnt_q)) + ATAN_RND) >> SH);
    mag_full = (PW'(x_q[XW-2:0]) * GAIN_INV + MAG_RND) >> 16;

    case (state_q)
      S_IDLE: ;
      S_PRE: begin
        cnt_d   = '0;
        state_d = S_ITER;
        if (x_q[XW-1] && !y_q[XW-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = Z_HALF;
        end else if (x_q[XW-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -Z_HALF;
        end else begin
          z_d = '0;
        end
      end
      S_ITER: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_z;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_z;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = S_SCALE;
      end
      S_SCALE: begin
        // A zero vector would otherwise accumulate the whole atan table into z.
        if (zero_q || x_q[XW-1]) mag_d = '0;
        else if (|mag_full[PW-1:MAG_W]) mag_d = '1;
        else mag_d = mag_full[MAG_W-1:0];
        ang_d   = zero_q ? '0 : ANG_W'((z_q + ZW'(4)) >>> 3);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      x_d     = {{(XW-IN_W){M[IN_W-1]}}, M};
      y_d     = {{(XW-IN_W){N[IN_W-1]}}, N};
      zero_d  = (M == '0) && (N == '0);
      state_d = S_PRE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

endmodule

// File: tb/tb_cordic_polar.sv
// Directed and swept checks of cordic_polar: latency, accuracy, quadrant
// boundaries, backpressure hold and reset abort.
module tb_cordic_polar;

  localparam int IN_W  = 15;
  localparam int MAG_W = 16;
  localparam int ANG_W = 13;
  localparam int ITER  = 14;
  localparam int LAT   = ITER + 2;
  localparam real PI   = 3.141592653589793;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  M;
  logic [IN_W-1:0]  N;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W-1:0] mag;
  logic [ANG_W-1:0] ang;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_polar #(.IN_W(IN_W), .MAG_W(MAG_W), .ANG_W(ANG_W), .ITER(ITER)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M         (M),
    .N         (N),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag       (mag),
    .ang       (ang),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tolerance-aware compare; a nonzero modw treats the values as circular.
  task automatic chk(input string tag, input int obs, input int exp, input int tol, input int modw);
    int d;
    d = obs - exp;
    if (modw > 0) begin
      d = d % modw;
      if (d > modw / 2) d -= modw;
      if (d < -(modw / 2)) d += modw;
    end
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic send(input int m, input int n);
    bit acc;
    int w;
    acc = 1'b0;
    w = 0;
    M = IN_W'(m);
    N = IN_W'(n);
    in_valid = 1'b1;
    while (!acc && w < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      w++;
    end
    in_valid = 1'b0;
    chk("accept", int'(acc), 1, 0, 0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic xfer(input int m, input int n, output int om, output int oa);
    int lat;
    send(m, n);
    wait_out(lat);
    chk("latency", lat, LAT, 0, 0);
    om = int'(mag);
    oa = int'($signed(ang));
  endtask

  initial begin
    int om, oa, lat, m0, a0, seen;
    int rm, rn, tries;
    real rmag, rang;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    M = '0;
    N = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", int'(out_valid), 0, 0, 0);
    chk("rst_in_ready", int'(in_ready), 0, 0, 0);
    chk("rst_busy", int'(busy), 0, 0, 0);
    chk("rst_mag", int'(mag), 0, 0, 0);
    chk("rst_ang", int'(ang), 0, 0, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    xfer(1000, 0, om, oa);
    chk("x_axis_mag", om, 1000, 1, 0);
    chk("x_axis_ang", oa, 0, 2, 8192);

    xfer(0, 1000, om, oa);
    chk("pos_y_mag", om, 1000, 1, 0);
    chk("pos_y_ang", oa, 2048, 2, 8192);
    xfer(0, -1000, om, oa);
    chk("neg_y_mag", om, 1000, 1, 0);
    chk("neg_y_ang", oa, -2048, 2, 8192);
    xfer(0, 0, om, oa);
    chk("zero_mag", om, 0, 0, 0);
    chk("zero_ang", oa, 0, 0, 0);

    xfer(-16384, -16384, om, oa);
    chk("min_mag", om, 23170, 2, 0);
    chk("min_ang", oa, -3072, 2, 8192);
    xfer(16383, -16384, om, oa);
    chk("q4_mag", om, 23170, 2, 0);
    chk("q4_ang", oa, -1024, 2, 8192);

    xfer(-1000, 0, om, oa);
    chk("neg_x_mag", om, 1000, 1, 0);
    chk("neg_x_ang", oa, -4096, 2, 8192);

    // Backpressure: result must hold while a pending sample waits.
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    send(1000, 0);
    wait_out(lat);
    chk("bp_latency", lat, LAT, 0, 0);
    m0 = int'(mag);
    a0 = int'($signed(ang));
    chk("bp_mag", m0, 1000, 1, 0);
    chk("bp_ang", a0, 0, 2, 8192);
    M = IN_W'(0);
    N = IN_W'(1000);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      chk("bp_hold", int'(out_valid && !in_ready && (int'(mag) == m0) && (int'($signed(ang)) == a0)), 1, 0, 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_in_ready", int'(in_ready), 1, 0, 0);
    chk("bp_out_valid", int'(out_valid), 1, 0, 0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_next_latency", lat, LAT, 0, 0);
    chk("bp_next_mag", int'(mag), 1000, 1, 0);
    chk("bp_next_ang", int'($signed(ang)), 2048, 2, 8192);

    // Reset during iteration i=5 aborts the sample.
    @(posedge clock);
    #1;
    send(0, 1000);
    repeat (6) @(posedge clock);
    #1;
    chk("abort_busy_before", int'(busy), 1, 0, 0);
    reset = 1'b1;
    #1;
    chk("abort_in_ready_rst", int'(in_ready), 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0, 0, 0);
    chk("abort_busy", int'(busy), 0, 0, 0);
    chk("abort_in_ready", int'(in_ready), 1, 0, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0, 0, 0);
    xfer(0, -1000, om, oa);
    chk("after_abort_mag", om, 1000, 1, 0);
    chk("after_abort_ang", oa, -2048, 2, 8192);

    // Random sweep against a floating-point reference, vectors of moderate length.
    for (int k = 0; k < 200; k++) begin
      tries = 0;
      do begin
        rm = int'($urandom_range(0, 32767)) - 16384;
        rn = int'($urandom_range(0, 32767)) - 16384;
        tries++;
      end while ((rm * rm + rn * rn < 36000000) && tries < 100);
      rmag = $sqrt(real'(rm) * real'(rm) + real'(rn) * real'(rn));
      rang = $atan2(real'(rn), real'(rm)) / PI * 4096.0;
      xfer(rm, rn, om, oa);
      chk("sweep_mag", om, int'(rmag), 5, 0);
      chk("sweep_ang", oa, int'(rang), 3, 8192);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
